// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: widths, state
// encoding, port identifiers and the address range check.
package ram_access_ctrl_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int CPU_ADDR_W = 16;
  localparam int STARVE_MAX = 3;
  localparam int CNT_W      = $clog2(STARVE_MAX + 1);
  localparam int ADDR_LIMIT = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  // A CPU word address is out of range when it lies beyond the RAM.
  function automatic logic addr_out_of_range(input logic [CPU_ADDR_W-1:0] addr);
    return (32'(addr) >= ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Bundle of the fetch port, data port and RAM-side signals.
// slave: the controller; master: the CPU/RAM environment around it.
interface ram_access_ctrl_if;
  import ram_access_ctrl_pkg::*;

  logic                  f_req;
  logic [CPU_ADDR_W-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_W-1:0]     f_rdata;
  logic                  f_err;

  logic                  d_req;
  logic                  d_we;
  logic [CPU_ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  logic                  ram_e;
  logic                  ram_r;
  logic                  ram_w;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_d;
  logic [DATA_W-1:0]     ram_out;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_e, ram_r, ram_w, ram_addr, ram_d
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_e, ram_r, ram_w, ram_addr, ram_d
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Fetch/data arbiter. Data wins by default; fetch wins once it has
// watched STARVE_MAX consecutive data grants, bounding its wait.
module ram_port_arbiter
  import ram_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  output logic f_gnt,
  output logic d_gnt
);

  logic [CNT_W-1:0] starve_cnt_r;
  logic             f_win_s;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    f_win_s = 1'b0;
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    if (rst) begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
    end else begin
      f_win_s = f_req && (!d_req || (starve_cnt_r == CNT_W'(STARVE_MAX)));
      f_gnt   = f_win_s;
      d_gnt   = d_req && !f_win_s;
    end
  end

  // Count data grants that fetch had to watch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!f_req || f_gnt) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (d_gnt && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-port access controller in front of the 16K x 16 RAM. One granted
// access per cycle is registered onto the RAM port; the RAM result is
// captured into a registered response on the owning port.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  ram_access_ctrl_if.slave        bus
);

  state_e                state_r;
  logic                  acc_port_r;
  logic                  acc_we_r;
  logic                  acc_err_r;

  logic                  ram_e_r;
  logic                  ram_r_r;
  logic                  ram_w_r;
  logic [ADDR_W-1:0]     ram_addr_r;
  logic [DATA_W-1:0]     ram_d_r;

  logic                  f_rvalid_r;
  logic [DATA_W-1:0]     f_rdata_r;
  logic                  f_err_r;
  logic                  d_rvalid_r;
  logic [DATA_W-1:0]     d_rdata_r;
  logic                  d_err_r;

  logic                  f_gnt_s;
  logic                  d_gnt_s;
  logic                  gnt_s;
  logic [CPU_ADDR_W-1:0] sel_addr_s;
  logic                  sel_we_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic                  sel_err_s;

  ram_port_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .f_req (bus.f_req),
    .d_req (bus.d_req),
    .f_gnt (f_gnt_s),
    .d_gnt (d_gnt_s)
  );

  assign gnt_s = f_gnt_s | d_gnt_s;

  // Select the winning request; fetches are always reads.
  always_comb begin
    sel_addr_s  = {CPU_ADDR_W{1'b0}};
    sel_we_s    = 1'b0;
    sel_wdata_s = {DATA_W{1'b0}};
    if (d_gnt_s) begin
      sel_addr_s  = bus.d_addr;
      sel_we_s    = bus.d_we;
      sel_wdata_s = bus.d_wdata;
    end else begin
      sel_addr_s  = bus.f_addr;
      sel_we_s    = 1'b0;
      sel_wdata_s = {DATA_W{1'b0}};
    end
    sel_err_s = addr_out_of_range(sel_addr_s);
  end

  // Access FSM: turn the registered access into a response, then register the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      acc_port_r <= PORT_F;
      acc_we_r   <= 1'b0;
      acc_err_r  <= 1'b0;
      ram_e_r    <= 1'b0;
      ram_r_r    <= 1'b0;
      ram_w_r    <= 1'b0;
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_d_r    <= {DATA_W{1'b0}};
      f_rvalid_r <= 1'b0;
      f_rdata_r  <= {DATA_W{1'b0}};
      f_err_r    <= 1'b0;
      d_rvalid_r <= 1'b0;
      d_rdata_r  <= {DATA_W{1'b0}};
      d_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCESS: begin
          f_rvalid_r <= (acc_port_r == PORT_F);
          f_err_r    <= (acc_port_r == PORT_F) && acc_err_r;
          f_rdata_r  <= ((acc_port_r == PORT_F) && !acc_err_r) ? bus.ram_out : {DATA_W{1'b0}};
          d_rvalid_r <= (acc_port_r == PORT_D);
          d_err_r    <= (acc_port_r == PORT_D) && acc_err_r;
          d_rdata_r  <= ((acc_port_r == PORT_D) && !acc_err_r && !acc_we_r) ?
                        bus.ram_out : {DATA_W{1'b0}};
        end
        default: begin
          f_rvalid_r <= 1'b0;
          f_err_r    <= 1'b0;
          f_rdata_r  <= {DATA_W{1'b0}};
          d_rvalid_r <= 1'b0;
          d_err_r    <= 1'b0;
          d_rdata_r  <= {DATA_W{1'b0}};
        end
      endcase

      if (gnt_s) begin
        state_r    <= ST_ACCESS;
        acc_port_r <= d_gnt_s ? PORT_D : PORT_F;
        acc_we_r   <= sel_we_s;
        acc_err_r  <= sel_err_s;
        ram_e_r    <= !sel_err_s;
        ram_r_r    <= !sel_err_s && !sel_we_s;
        ram_w_r    <= !sel_err_s && sel_we_s;
        ram_addr_r <= sel_err_s ? {ADDR_W{1'b0}} : sel_addr_s[ADDR_W-1:0];
        ram_d_r    <= (!sel_err_s && sel_we_s) ? sel_wdata_s : {DATA_W{1'b0}};
      end else begin
        state_r    <= ST_IDLE;
        acc_port_r <= PORT_F;
        acc_we_r   <= 1'b0;
        acc_err_r  <= 1'b0;
        ram_e_r    <= 1'b0;
        ram_r_r    <= 1'b0;
        ram_w_r    <= 1'b0;
        ram_addr_r <= {ADDR_W{1'b0}};
        ram_d_r    <= {DATA_W{1'b0}};
      end
    end
  end

  // Reset masks the registered outputs in the same cycle, so a pending
  // write never reaches the RAM and a pending response never escapes.
  assign bus.f_gnt    = f_gnt_s;
  assign bus.d_gnt    = d_gnt_s;
  assign bus.ram_e    = ram_e_r & ~rst;
  assign bus.ram_r    = ram_r_r & ~rst;
  assign bus.ram_w    = ram_w_r & ~rst;
  assign bus.ram_addr = ram_addr_r & {ADDR_W{~rst}};
  assign bus.ram_d    = ram_d_r & {DATA_W{~rst}};
  assign bus.f_rvalid = f_rvalid_r & ~rst;
  assign bus.f_err    = f_err_r & ~rst;
  assign bus.f_rdata  = f_rdata_r & {DATA_W{~rst}};
  assign bus.d_rvalid = d_rvalid_r & ~rst;
  assign bus.d_err    = d_err_r & ~rst;
  assign bus.d_rdata  = d_rdata_r & {DATA_W{~rst}};

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: a bench-side RAM, directed
// scenarios and randomized traffic, all compared against a transaction
// level reference (arbitration rule, access pipeline, shadow memory).
module tb_ram_access_ctrl;

  localparam int STARVE_MAX = 3;

  typedef struct packed {
    logic        valid;
    logic        port_d;
    logic        we;
    logic        err;
    logic        known;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ram_access_ctrl_if bus ();

  ram_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Bench RAM: combinational read, write on the closing edge.
  logic [15:0] mem [0:16383];
  assign bus.ram_out = bus.ram_r ? mem[bus.ram_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (bus.ram_e && bus.ram_w) mem[bus.ram_addr] <= bus.ram_d;
  end

  // Reference state
  logic [15:0] ref_mem [int];
  item_t       nxt, acc, rsp;
  int          d_run;
  int          n_pass, n_total;

  // Requester state
  logic        fr_pend, dr_pend, dr_we;
  logic [15:0] fr_addr, dr_addr, dr_wdata;
  logic [15:0] pool [0:7];

  logic        obs_f, obs_d, last_d_err;
  logic [15:0] last_f_rdata, last_d_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic set_f(input logic [15:0] a);
    fr_pend = 1'b1;
    fr_addr = a;
  endtask

  task automatic set_d(input logic we, input logic [15:0] a, input logic [15:0] wd);
    dr_pend  = 1'b1;
    dr_we    = we;
    dr_addr  = a;
    dr_wdata = wd;
  endtask

  // One clock cycle: drive requests, check grants, RAM port and responses.
  task automatic cycle(input logic do_rst);
    logic ef, ed;
    @(posedge clk);
    #1;
    rsp = acc;
    acc = nxt;
    nxt = '0;
    if (do_rst) begin
      rsp = '0;
      acc = '0;
    end
    if (acc.valid) begin
      if (acc.err || acc.we) begin
        acc.rdata = 16'h0000;
        acc.known = 1'b1;
      end else begin
        acc.known = ref_mem.exists(int'(acc.addr[13:0]));
        acc.rdata = acc.known ? ref_mem[int'(acc.addr[13:0])] : 16'h0000;
      end
      if (!acc.err && acc.we) ref_mem[int'(acc.addr[13:0])] = acc.wdata;
    end
    rst         = do_rst;
    bus.f_req   = fr_pend;
    bus.f_addr  = fr_addr;
    bus.d_req   = dr_pend;
    bus.d_we    = dr_we;
    bus.d_addr  = dr_addr;
    bus.d_wdata = dr_wdata;
    @(negedge clk);

    ef = !do_rst && fr_pend && (!dr_pend || d_run == STARVE_MAX);
    ed = !do_rst && dr_pend && !ef;
    chk("f_gnt", 32'(bus.f_gnt), 32'(ef));
    chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
    obs_f = bus.f_gnt;
    obs_d = bus.d_gnt;

    if (acc.valid && !acc.err) begin
      chk("ram_e", 32'(bus.ram_e), 32'd1);
      chk("ram_r", 32'(bus.ram_r), 32'(!acc.we));
      chk("ram_w", 32'(bus.ram_w), 32'(acc.we));
      chk("ram_addr", 32'(bus.ram_addr), 32'(acc.addr[13:0]));
      if (acc.we) chk("ram_d", 32'(bus.ram_d), 32'(acc.wdata));
    end else begin
      chk("ram_e_off", 32'(bus.ram_e), 32'd0);
      chk("ram_r_off", 32'(bus.ram_r), 32'd0);
      chk("ram_w_off", 32'(bus.ram_w), 32'd0);
      chk("ram_addr_off", 32'(bus.ram_addr), 32'd0);
      chk("ram_d_off", 32'(bus.ram_d), 32'd0);
    end

    chk("f_rvalid", 32'(bus.f_rvalid), 32'(rsp.valid && !rsp.port_d));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(rsp.valid && rsp.port_d));
    if (rsp.valid && !rsp.port_d) begin
      chk("f_err", 32'(bus.f_err), 32'(rsp.err));
      if (rsp.known) chk("f_rdata", 32'(bus.f_rdata), 32'(rsp.rdata));
    end
    if (rsp.valid && rsp.port_d) begin
      chk("d_err", 32'(bus.d_err), 32'(rsp.err));
      if (rsp.known) chk("d_rdata", 32'(bus.d_rdata), 32'(rsp.rdata));
    end
    if (do_rst) begin
      chk("rst_f_out", 32'({bus.f_err, bus.f_rdata}), 32'd0);
      chk("rst_d_out", 32'({bus.d_err, bus.d_rdata}), 32'd0);
    end
    if (bus.f_rvalid) last_f_rdata = bus.f_rdata;
    if (bus.d_rvalid) begin
      last_d_rdata = bus.d_rdata;
      last_d_err   = bus.d_err;
    end

    // Fetch has watched d_run consecutive data grants while waiting.
    if (do_rst || !fr_pend || ef) d_run = 0;
    else if (ed && d_run < STARVE_MAX) d_run++;

    if (ef) begin
      nxt.valid = 1'b1;
      nxt.addr  = fr_addr;
      nxt.err   = (fr_addr[15:14] != 2'b00);
      fr_pend   = 1'b0;
    end else if (ed) begin
      nxt.valid  = 1'b1;
      nxt.port_d = 1'b1;
      nxt.we     = dr_we;
      nxt.addr   = dr_addr;
      nxt.wdata  = dr_wdata;
      nxt.err    = (dr_addr[15:14] != 2'b00);
      dr_pend    = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    fr_pend = 1'b0;
    dr_pend = 1'b0;
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic run_until_done(input int bound);
    int k;
    k = 0;
    while ((fr_pend || dr_pend) && k < bound) begin
      cycle(1'b0);
      k++;
    end
    chk("grant_wait", 32'(fr_pend | dr_pend), 32'd0);
    fr_pend = 1'b0;
    dr_pend = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [1:0]  hi;
    logic [13:0] lo;
    if ($urandom_range(0, 9) == 0) begin
      hi = 2'($urandom_range(1, 3));
      lo = 14'($urandom);
      return {hi, lo};
    end
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    n_pass = 0; n_total = 0; d_run = 0;
    nxt = '0; acc = '0; rsp = '0;
    fr_pend = 1'b0; dr_pend = 1'b0; dr_we = 1'b0;
    fr_addr = 16'h0; dr_addr = 16'h0; dr_wdata = 16'h0;
    last_f_rdata = 16'h0; last_d_rdata = 16'h0; last_d_err = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = 16'h0; bus.d_req = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
    pool[0] = 16'h0000;
    pool[1] = 16'h3FFF;
    pool[2] = 16'h0123;
    for (int i = 3; i < 8; i++) pool[i] = {2'b00, 14'($urandom)};

    // Reset with both requests pending; fetch targets an out-of-range address.
    set_f(16'hC000);
    set_d(1'b1, 16'h0000, 16'h5678);
    repeat (3) cycle(1'b1);
    run_until_done(8);
    idle(3);

    // Store then load of the same word on consecutive grants.
    set_d(1'b1, 16'h0123, 16'hBEEF);
    cycle(1'b0);
    set_d(1'b0, 16'h0123, 16'h0000);
    cycle(1'b0);
    idle(3);
    chk("store_load", 32'(last_d_rdata), 32'h0000BEEF);

    // Out-of-range data load.
    set_d(1'b0, 16'h4001, 16'h0000);
    run_until_done(4);
    idle(3);
    chk("d_err_resp", 32'({last_d_err, last_d_rdata}), 32'h00010000);

    // Reset during the access cycle of a store drops it.
    set_d(1'b1, 16'h0123, 16'h1111);
    cycle(1'b0);
    cycle(1'b1);
    idle(2);
    set_d(1'b0, 16'h0123, 16'h0000);
    run_until_done(4);
    idle(3);
    chk("rst_drop", 32'(last_d_rdata), 32'h0000BEEF);

    // Boundary words fetched alternately at full rate.
    set_d(1'b1, 16'h3FFF, 16'h1234);
    cycle(1'b0);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      set_f((i % 2 == 0) ? 16'h3FFF : 16'h0000);
      cycle(1'b0);
    end
    idle(3);
    chk("alt_fetch_last", 32'(last_f_rdata), 32'h00005678);

    // Give every pool address a known value.
    for (int i = 0; i < 8; i++) begin
      set_d(1'b1, pool[i], 16'($urandom));
      cycle(1'b0);
    end
    idle(2);

    // Both ports saturated: grants must follow D,D,D,F.
    for (int i = 0; i < 16; i++) begin
      if (!fr_pend) set_f(pool[$urandom_range(0, 7)]);
      if (!dr_pend) set_d(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom));
      cycle(1'b0);
      chk("starve_pattern", 32'({obs_f, obs_d}), (i % 4 == 3) ? 32'd2 : 32'd1);
    end
    idle(3);

    // Randomized traffic with cancels and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!fr_pend && $urandom_range(0, 2) != 0) set_f(rand_addr());
      if (!dr_pend && $urandom_range(0, 2) != 0)
        set_d(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      if (fr_pend && $urandom_range(0, 15) == 0) fr_pend = 1'b0;
      if (dr_pend && $urandom_range(0, 15) == 0) dr_pend = 1'b0;
      cycle($urandom_range(0, 63) == 0);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Two-port access controller that sits directly upstream of the 16K x 16 word RAM in the RISC processor. It arbitrates between the instruction-fetch port (read-only) and the data load/store port, registers one access per cycle onto the RAM's single E/R/W/ADDR/D port, and captures the RAM output into registered responses. It also range-checks 16-bit CPU addresses against the 14-bit RAM space. A starvation guard bounds how long fetch can be locked out by data traffic.

## Interface
- ADDR_W, 14, RAM address width (word addressed)
- DATA_W, 16, data width
- STARVE_MAX, 3, max consecutive data grants while fetch is pending

- CLK  in  1  rising-edge clock, shared with the RAM
- RST  in  1  synchronous, active-high reset
- F_REQ  in  1  fetch request, held until F_GNT
- F_ADDR  in  16  fetch word address
- F_GNT  out  1  fetch request accepted this cycle (combinational)
- F_RVALID  out  1  fetch response valid, one-cycle pulse
- F_RDATA  out  16  fetch read data
- F_ERR  out  1  fetch address out of range (qualifies F_RVALID)
- D_REQ  in  1  data request, held until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  16  data word address
- D_WDATA  in  16  store data
- D_GNT  out  1  data request accepted this cycle (combinational)
- D_RVALID  out  1  data response (load data or store ack), one-cycle pulse
- D_RDATA  out  16  load data; 0 for stores and errors
- D_ERR  out  1  data address out of range (qualifies D_RVALID)
- RAM_E, RAM_R, RAM_W  out  1 each  RAM enable / read / write
- RAM_ADDR  out  14  RAM address
- RAM_D  out  16  RAM write data
- RAM_OUT  in  16  RAM read data (combinational from RAM cells; undefined when RAM_R low)

## Operation
- States: IDLE (no access registered), ACCESS (one access registered). A new grant is allowed in both states, so throughput is one access per cycle.
- Grant: at most one of F_GNT/D_GNT per cycle. Data wins by default. Fetch wins if F_REQ && (!D_REQ || starve_cnt == STARVE_MAX).
- starve_cnt: +1 when D_GNT while F_REQ is high. Cleared on F_GNT or whenever F_REQ is low. Saturates at STARVE_MAX.
- Granted request is registered: port id, we, addr[13:0], wdata, err = (addr[15:14] != 0). Next state is ACCESS; with no grant the next state is IDLE.
- ACCESS with err=0: drive RAM_E=1, RAM_R=!we, RAM_W=we, RAM_ADDR, RAM_D=wdata. Write commits on the closing edge. For reads, RAM_OUT is captured at the closing edge.
- ACCESS with err=1: all RAM_* held at 0 (no RAM access). Response has ERR=1, RDATA=0.
- Response: in the cycle after ACCESS, the owning port's RVALID=1 for exactly one cycle. ERR is qualified by RVALID. Stores return RDATA=0.
- Outside valid accesses all RAM_* are 0. No spurious enable or write ever occurs.
- Fetch requests ignore D_WE/D_WDATA and are always reads.

## Timing
- Reset: state IDLE, starve_cnt 0, every output 0 (GNT, RVALID, RDATA, ERR, all RAM_*).
- RST mid-operation: the registered access and any pending response are dropped. No RVALID follows, and no RAM write occurs in the reset cycle.
- Latency: grant in cycle N, RAM access in N+1, RVALID/RDATA in N+2.
- Store in N+1 followed by a load of the same address in N+2 returns the new data (write commits before the read cycle).
- Back-to-back grants produce back-to-back RVALIDs, in order, on the owning ports.
- Requester must hold REQ, ADDR, WE and WDATA stable until GNT. Dropping REQ before GNT is allowed and cancels the request.
- Fetch waits at most STARVE_MAX+1 cycles under continuous data load.

## Structure
- Shared package: state encoding (IDLE/ACCESS), port id constants (PORT_F, PORT_D), ADDR_LIMIT = 2^ADDR_W, default widths.
- Sub-module ram_port_arbiter: combinational grant plus starve_cnt register. The access/response registers and RAM drive stay in the top.

## Test plan
- Reset with requests pending -> all outputs 0. First grant occurs only after RST deasserts.
- Store 0xBEEF to 0x0123, then load 0x0123 next cycle -> D_RVALID store ack (RDATA 0), then D_RVALID with 0xBEEF at N+3.
- D_ADDR=0x4001 load -> D_GNT, RAM_E stays 0, D_RVALID with D_ERR=1, D_RDATA=0. F_ADDR=0xC000 behaves likewise on F_ERR.
- F_REQ and D_REQ held continuously -> grant pattern D,D,D,F repeating. Each RVALID appears on the correct port 2 cycles after its grant.
- Preload 0x3FFF=0x1234 and 0x0000=0x5678, alternate fetches of both at one per cycle -> F_RDATA 0x1234,0x5678,... with F_RVALID held high.
- Assert RST in the cycle after a store grant -> no RAM_W pulse, no D_RVALID, and a later read shows the old data.
